// File: rtl/bsr_seg_chain.sv
// bsr_seg_chain: segmented boundary-scan chain of NUM_CH channels, each
// CH_WIDTH bits wide. A scan-loaded segment-select register places every
// channel either in the active data chain or in a 1-bit bypass flop.
// Macro BSR_SEG_CHAIN_LEN_EN enables the chain_len popcount output; when it
// is undefined chain_len is tied to zero.
module bsr_seg_chain #(
    parameter int NUM_CH   = 6,
    parameter int CH_WIDTH = 32,
    localparam int LEN_W   = $clog2(NUM_CH*CH_WIDTH+1)
) (
    input  logic                         tck,
    input  logic                         trst,
    input  logic                         ir_select,
    input  logic                         capture_dr,
    input  logic                         shift_dr,
    input  logic                         update_dr,
    input  logic                         mode,
    input  logic                         tdi,
    output logic                         tdo,
    input  logic [NUM_CH*CH_WIDTH-1:0]   parallel_in,
    output logic [NUM_CH*CH_WIDTH-1:0]   parallel_out,
    output logic [LEN_W-1:0]             chain_len
);

    logic [NUM_CH-1:0][CH_WIDTH-1:0] sr;
    logic [NUM_CH-1:0][CH_WIDTH-1:0] up;
    logic [NUM_CH-1:0][CH_WIDTH-1:0] sr_shift;
    logic [NUM_CH-1:0]               byp;
    logic [NUM_CH-1:0]               sel_sr;
    logic [NUM_CH-1:0]               sel;
    logic [NUM_CH-1:0]               sel_sr_shift;
    logic [NUM_CH-1:0]               seg_in;
    logic [NUM_CH-1:0]               seg_out;

    // Serial output of each segment: shift stage LSB when selected, else bypass flop
    always_comb begin
        seg_out = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            seg_out[i] = sel[i] ? sr[i][0] : byp[i];
        end
    end

    // Serial input of each segment: tdi for channel 0, previous segment otherwise
    always_comb begin
        seg_in    = '0;
        seg_in[0] = tdi;
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            seg_in[i] = seg_out[i-1];
        end
    end

    // Next values for one shift step (data enters the MSB, leaves at bit 0)
    always_comb begin
        sr_shift = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sr_shift[i]             = sr[i] >> 1;
            sr_shift[i][CH_WIDTH-1] = seg_in[i];
        end
        sel_sr_shift           = sel_sr >> 1;
        sel_sr_shift[NUM_CH-1] = tdi;
    end

    // Serial out of whichever DR is active
    always_comb begin
        tdo = ir_select ? sel_sr[0] : seg_out[NUM_CH-1];
    end

    // DR state: strobe priority capture > shift > update, only the active DR moves
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            sr     <= '0;
            up     <= '0;
            byp    <= '0;
            sel_sr <= '1;
            sel    <= '1;
        end else if (capture_dr) begin
            if (ir_select) begin
                sel_sr <= sel;
            end else begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (sel[i]) sr[i]  <= parallel_in[i*CH_WIDTH +: CH_WIDTH];
                    else        byp[i] <= 1'b0;
                end
            end
        end else if (shift_dr) begin
            if (ir_select) begin
                sel_sr <= sel_sr_shift;
            end else begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (sel[i]) sr[i]  <= sr_shift[i];
                    else        byp[i] <= seg_in[i];
                end
            end
        end else if (update_dr) begin
            if (ir_select) begin
                sel <= sel_sr;
            end else begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (sel[i]) up[i] <= sr[i];
                end
            end
        end
    end

    // Override mux: selected channels drive their update latch when mode is set
    always_comb begin
        parallel_out = parallel_in;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (mode && sel[i]) parallel_out[i*CH_WIDTH +: CH_WIDTH] = up[i];
        end
    end

`ifdef BSR_SEG_CHAIN_LEN_EN
    int unsigned sel_cnt;

    // Chain length: full width per selected channel, one bit per bypassed one
    always_comb begin
        sel_cnt = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel_cnt = sel_cnt + 32'(sel[i]);
        end
        chain_len = LEN_W'(CH_WIDTH * sel_cnt + (NUM_CH - sel_cnt));
    end
`else
    // Chain length reporting not built
    always_comb begin
        chain_len = '0;
    end
`endif

endmodule

// File: doc/bsr_seg_chain.md
# bsr_seg_chain

Parametrised, segmented boundary-scan chain for the JTAG test logic. It replaces the fixed, hand-wired chain of per-signal scan cells with one block of `NUM_CH` equal-width channels. A scan-selected segment-select register puts each channel either in the active chain or in a 1-bit bypass, so only selected channels are captured, updated and overridden. It sits between the TAP controller's DR strobes and the core-to-memory signals.

## Interface
- `NUM_CH`, default 6: number of channels. Channel 0 is nearest `tdi`.
- `CH_WIDTH`, default 32: bits per channel. Narrower signals use the low bits; the rest are tied to 0.
- `tck` input, 1: scan clock, the only clock. All state updates on its rising edge.
- `trst` input, 1: asynchronous, active-low reset.
- `ir_select` input, 1: 1 = the segment-select register is the active DR; 0 = the channel chain is the active DR.
- `capture_dr`, `shift_dr`, `update_dr` inputs, 1 each: TAP state strobes.
- `mode` input, 1: override enable for selected channels.
- `tdi` input, 1: serial in.
- `tdo` output, 1: serial out of the active DR.
- `parallel_in` input, `NUM_CH*CH_WIDTH`: system values. Channel i occupies bits [i*CH_WIDTH +: CH_WIDTH].
- `parallel_out` output, `NUM_CH*CH_WIDTH`: values driven to the system.
- `chain_len` output, `$clog2(NUM_CH*CH_WIDTH+1)`: current data-chain length in bits.

## Operation
- **State**
  - `sr[i]` is the CH_WIDTH-bit shift stage of each channel.
  - `up[i]` is the CH_WIDTH-bit update latch of each channel.
  - `byp[i]` is a 1-bit bypass flop per channel.
  - `sel_sr` and `sel` are each NUM_CH bits.
- **Reset** (`trst`=0): `sr`, `up` and `byp` clear to 0; `sel_sr` and `sel` are set to all ones.
- **Strobe priority** when more than one strobe is asserted: capture > shift > update.
- **Select path** (`ir_select`=1):
  - `capture_dr`: `sel_sr` <= `sel`.
  - `shift_dr`: `sel_sr` <= {`tdi`, `sel_sr`[NUM_CH-1:1]}.
  - `update_dr`: `sel` <= `sel_sr`.
  - `tdo` = `sel_sr`[0].
  - The data path holds.
- **Data path** (`ir_select`=0):
  - Segment i is `sr[i]` if `sel[i]`=1, else `byp[i]`.
  - Chain order: `tdi` -> seg 0 -> seg 1 -> … -> seg NUM_CH-1 -> `tdo`.
  - Within `sr[i]`, serial data enters bit CH_WIDTH-1, shifts toward bit 0 and leaves at bit 0.
  - `tdo` = serial out of seg NUM_CH-1.
  - `capture_dr`: selected `sr[i]` <= `parallel_in` channel i; unselected `byp[i]` <= 0.
  - `shift_dr`: every segment shifts one position.
  - `update_dr`: `up[i]` <= `sr[i]` for selected channels only. Unselected `up[i]` keep their value.
  - An unselected `sr[i]` holds its contents and does not shift.
  - The select path holds.
- **Output mux**: `parallel_out` channel i = (`mode` & `sel[i]`) ? `up[i]` : `parallel_in` channel i. It is combinational; there is no added latency.
- `chain_len` = CH_WIDTH × popcount(`sel`) + (NUM_CH − popcount(`sel`)).

## Timing
- Captures, shifts and updates take effect at the rising `tck` edge where the strobe is high. There is a 1-cycle latency from strobe to register.
- `tdo` is combinational from current state and changes after the rising edge. Falling-edge retiming belongs to the TAP, not this block.
- A change to `sel` affects the chain order and `parallel_out` from the cycle after `update_dr`.
- A `trst` assertion mid-shift clears state immediately and asynchronously. `sel` returns to all ones, so the full chain is active.
- Deassertion is asynchronous, and state updates resume on the first rising edge after it.
- Shifting more bits than `chain_len` is legal: bits fall off `tdo`.
- Strobes are ignored while `trst`=0.

## Configuration
- `BSR_SEG_CHAIN_LEN_EN` defined: `chain_len` is computed as specified.
- `BSR_SEG_CHAIN_LEN_EN` undefined: `chain_len` is tied to 0 and no popcount logic is built. Everything else is identical.

## Test plan
All scenarios use NUM_CH=6, CH_WIDTH=32, with the macro defined unless stated.

1. Pulse `trst` low with `mode`=0 -> `sel`=6'b111111, `chain_len`=192, `parallel_out`=`parallel_in`, `tdo`=0.
2. Set channel 5=0x00000019 and channel 0=0x00000064. Capture, then shift 192 bits with `tdi`=0 -> the first 32 `tdo` bits are 0x19 LSB-first and the last 32 are 0x64 LSB-first.
3. With `ir_select`=1, shift 6 bits LSB-first to select only channel 3, then update -> `sel`=6'b001000 and `chain_len`=37. A data capture plus 37 shifts returns channel 3's value after 2 bypass zeros.
4. With `sel`=6'b001000, shift 0x00000019 into channel 3, update, and set `mode`=1 -> `parallel_out` channel 3=0x19 and all other channels equal `parallel_in`.
5. After scenario 4, select 6'b000001, shift 0x00000064 and update -> channel 0 is overridden to 0x64 and channel 3 follows `parallel_in`. Reselect 6'b001001 -> channel 3 again shows the retained 0x19.
6. Assert `trst` mid-shift (bit 17 of 37) -> `sel`=all ones and all `up`=0. With `mode`=1, `parallel_out`=0. With the macro undefined, `chain_len`=0 throughout.
